// File: rtl/no_brdr_out_collector_pkg.sv
// Shared definitions for the no-border output collector: FSM states,
// output conversion modes and the border-width helper.
package no_brdr_out_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned OUT_CLAMP = 0;
  localparam int unsigned OUT_ABS   = 1;

  function automatic int unsigned border_width(input int unsigned mask_width);
    return mask_width - 1;
  endfunction

endpackage

// File: rtl/no_brdr_out_collector_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of 2 (>= 2).
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNTW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNTW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/no_brdr_out_collector.sv
// Receive-side collector for the 7x7 no-border filter: crops the border,
// converts to unsigned pixels and buffers them. Optional macro NO_BRDR_CLIP_CNT_EN adds clip_cnt.
module no_brdr_out_collector
  import no_brdr_out_collector_pkg::*;
#(
  parameter int unsigned ROW_WIDTH  = 93,
  parameter int unsigned IMG_HEIGHT = 93,
  parameter int unsigned PIX_BIT    = 8,
  parameter int unsigned MASK_WIDTH = 7,
  parameter int unsigned OUT_MODE   = 0,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset_in,
  input  logic               frame_start,
  input  logic [PIX_BIT:0]   flt_q,
  input  logic               flt_ready,
  output logic [PIX_BIT-1:0] pix_out,
  output logic               pix_out_valid,
  input  logic               pix_out_ready,
  output logic               frame_done,
  output logic               overflow,
  output logic               busy
`ifdef NO_BRDR_CLIP_CNT_EN
  ,
  output logic [15:0]        clip_cnt
`endif
);

  localparam int unsigned BORDER = border_width(MASK_WIDTH);
  localparam int unsigned CW     = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
  localparam int unsigned RW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned QW     = PIX_BIT + 1;

  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic               start_accept;
  logic               sample;
  logic               keep;
  logic               last_sample;
  logic [QW-1:0]      mag;
  logic [PIX_BIT-1:0] conv_data;
  logic               conv_clip;
  logic [PIX_BIT-1:0] conv_pix;
  logic               conv_valid;
  logic [PIX_BIT-1:0] fifo_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;

  // A frame_start cycle only restarts counting; any flt_ready alongside it is discarded.
  assign start_accept = frame_start && (state == ST_IDLE || state == ST_RUN);
  assign sample       = (state == ST_RUN) && flt_ready && !frame_start;
  assign keep         = sample && (row >= RW'(BORDER)) && (col >= CW'(BORDER));
  assign last_sample  = sample && (row == RW'(IMG_HEIGHT - 1)) && (col == CW'(ROW_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset_in) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    busy       = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (frame_start) state_next = ST_RUN;
      end
      ST_RUN:   if (last_sample) state_next = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && !conv_valid) state_next = ST_DONE;
      ST_DONE: begin
        frame_done = 1'b1;
        state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_in || start_accept) begin
      row <= '0;
      col <= '0;
    end else if (sample) begin
      if (col == CW'(ROW_WIDTH - 1)) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Negating the most negative input overflows into bit PIX_BIT, which flags saturation.
  always_comb begin
    mag       = flt_q[PIX_BIT] ? (~flt_q + QW'(1)) : flt_q;
    conv_data = flt_q[PIX_BIT-1:0];
    conv_clip = 1'b0;
    if (OUT_MODE == OUT_ABS) begin
      if (mag[PIX_BIT]) begin
        conv_data = '1;
        conv_clip = 1'b1;
      end else begin
        conv_data = mag[PIX_BIT-1:0];
      end
    end else if (flt_q[PIX_BIT]) begin
      conv_data = '0;
      conv_clip = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      conv_valid <= 1'b0;
      conv_pix   <= '0;
    end else begin
      conv_valid <= keep;
      if (keep) conv_pix <= conv_data;
    end
  end

  assign pop = !fifo_empty && pix_out_ready;

  sync_fifo_fwft #(
    .WIDTH (PIX_BIT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_in  (reset_in),
    .push      (conv_valid),
    .push_data (conv_pix),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pix_out_valid = !fifo_empty;
  assign pix_out       = fifo_empty ? '0 : fifo_data;

  always_ff @(posedge clk) begin
    if (reset_in || start_accept)            overflow <= 1'b0;
    else if (conv_valid && fifo_full && !pop) overflow <= 1'b1;
  end

`ifdef NO_BRDR_CLIP_CNT_EN
  always_ff @(posedge clk) begin
    if (reset_in || start_accept)               clip_cnt <= '0;
    else if (keep && conv_clip && clip_cnt != '1) clip_cnt <= clip_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_no_brdr_out_collector.sv
// Randomised self-checking bench: a clamp-mode and an abs-mode collector share stimulus
// and are compared against a position/conversion model of the cropped frame.
module tb_no_brdr_out_collector;

  localparam int W    = 10;
  localparam int H    = 8;
  localparam int PB   = 8;
  localparam int QW   = PB + 1;
  localparam int MW   = 7;
  localparam int MAXV = (1 << PB) - 1;
  localparam int IDX5 = MW * W + MW - 1;  // raster index of the fifth kept sample

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_in = 1'b1;
  logic          frame_start = 1'b0;
  logic          flt_ready = 1'b0;
  logic          pix_out_ready = 1'b0;
  logic [QW-1:0] flt_q = '0;
  logic [PB-1:0] pix_a, pix_b;
  logic          val_a, val_b, done_a, done_b, ovf_a, ovf_b, busy_a, busy_b;
`ifdef NO_BRDR_CLIP_CNT_EN
  logic [15:0]   clip_a, clip_b;
`endif

  no_brdr_out_collector #(
    .ROW_WIDTH(W), .IMG_HEIGHT(H), .PIX_BIT(PB), .MASK_WIDTH(MW), .OUT_MODE(0), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .reset_in(reset_in), .frame_start(frame_start), .flt_q(flt_q),
    .flt_ready(flt_ready), .pix_out(pix_a), .pix_out_valid(val_a),
    .pix_out_ready(pix_out_ready), .frame_done(done_a), .overflow(ovf_a), .busy(busy_a)
`ifdef NO_BRDR_CLIP_CNT_EN
    , .clip_cnt(clip_a)
`endif
  );

  no_brdr_out_collector #(
    .ROW_WIDTH(W), .IMG_HEIGHT(H), .PIX_BIT(PB), .MASK_WIDTH(MW), .OUT_MODE(1), .FIFO_DEPTH(16)
  ) dut_b (
    .clk(clk), .reset_in(reset_in), .frame_start(frame_start), .flt_q(flt_q),
    .flt_ready(flt_ready), .pix_out(pix_b), .pix_out_valid(val_b),
    .pix_out_ready(pix_out_ready), .frame_done(done_b), .overflow(ovf_b), .busy(busy_b)
`ifdef NO_BRDR_CLIP_CNT_EN
    , .clip_cnt(clip_b)
`endif
  );

  int passed = 0;
  int total  = 0;
  int got_a[$], got_b[$], exp_a[$], exp_b[$];
  int ndone_a, ndone_b, n, clip_exp_a, clip_exp_b;

  function automatic bit kept_at(input int idx);
    return ((idx / W) >= MW - 1) && ((idx % W) >= MW - 1);
  endfunction

  function automatic int conv_clamp(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int conv_abs(input int v);
    int m = (v < 0) ? -v : v;
    return (m > MAXV) ? MAXV : m;
  endfunction

  function automatic int rnd_v();
    return int'($urandom_range(2 * MAXV + 1)) - (MAXV + 1);
  endfunction

  task automatic clear_model();
    got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
    ndone_a = 0; ndone_b = 0; n = 0; clip_exp_a = 0; clip_exp_b = 0;
  endtask

  // One clock of stimulus; handshakes and done pulses are recorded before the next edge.
  task automatic cyc(input logic fs, input logic fr, input int v, input logic rdy);
    @(negedge clk);
    frame_start = fs; flt_ready = fr; flt_q = QW'(v); pix_out_ready = rdy;
    #1;
    if (val_a && rdy) got_a.push_back(int'(pix_a));
    if (val_b && rdy) got_b.push_back(int'(pix_b));
    if (done_a) ndone_a++;
    if (done_b) ndone_b++;
  endtask

  task automatic sample(input int v, input logic rdy);
    if (kept_at(n)) begin
      exp_a.push_back(conv_clamp(v));
      exp_b.push_back(conv_abs(v));
      if (v < 0) clip_exp_a++;
      if (v < -MAXV) clip_exp_b++;
    end
    n++;
    cyc(1'b0, 1'b1, v, rdy);
  endtask

  task automatic start_frame(input logic rdy);
    clear_model();
    cyc(1'b1, 1'b0, 0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_in = 1'b1; frame_start = 1'b0; flt_ready = 1'b0; pix_out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_in = 1'b0;
    clear_model();
  endtask

  task automatic wait_done(input int budget, output bit ok);
    for (int k = 0; k < budget && !(ndone_a > 0 && ndone_b > 0); k++) cyc(1'b0, 1'b0, 0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 0, 1'b1);
    ok = (ndone_a > 0) && (ndone_b > 0);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if ({pix_a, val_a, done_a, ovf_a, busy_a} !== '0) $display("FAIL reset_a got %h want 0", {pix_a, val_a, done_a, ovf_a, busy_a});
    else passed++;
    total++;
    if ({pix_b, val_b, done_b, ovf_b, busy_b} !== '0) $display("FAIL reset_b got %h want 0", {pix_b, val_b, done_b, ovf_b, busy_b});
    else passed++;
`ifdef NO_BRDR_CLIP_CNT_EN
    total++;
    if ({clip_a, clip_b} !== '0) $display("FAIL reset_clip got %h/%h want 0", clip_a, clip_b);
    else passed++;
`endif
  endtask

  task automatic test_basic_crop();
    bit ok;
    do_reset();
    start_frame(1'b1);
    for (int i = 0; i < W * H; i++) sample((i % W) + 10 * (i / W), 1'b1);
    wait_done(200, ok);
    total++;
    if (!ok) $display("FAIL crop_timeout done %0d/%0d want 1/1", ndone_a, ndone_b); else passed++;
    total++;
    if (got_a.size() != 8 || got_b.size() != 8) $display("FAIL crop_count got %0d/%0d want 8", got_a.size(), got_b.size());
    else passed++;
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
      total++;
      if (got_a[i] !== exp_a[i]) $display("FAIL crop_word%0d got %0d want %0d", i, got_a[i], exp_a[i]); else passed++;
    end
    total++;
    if (got_b.size() > 0 && got_b[0] !== 66) $display("FAIL crop_first_b got %0d want 66", got_b[0]); else passed++;
    total++;
    if (ndone_a != 1 || ovf_a !== 1'b0 || busy_a !== 1'b0) $display("FAIL crop_status done=%0d ovf=%b busy=%b want 1/0/0", ndone_a, ovf_a, busy_a);
    else passed++;
  endtask

  task automatic test_conversion();
    bit ok;
    int cvals[5];
    int j = 0;
    int v;
    cvals = '{-5, 0, 255, -256, 200};
    do_reset();
    start_frame(1'b1);
    for (int i = 0; i < W * H; i++) begin
      if (kept_at(i)) begin
        v = (j < 5) ? cvals[j] : rnd_v();
        j++;
      end else begin
        v = rnd_v();
      end
      sample(v, 1'b1);
    end
    wait_done(200, ok);
    total++;
    if (!ok || got_a.size() != exp_a.size() || got_b.size() != exp_b.size())
      $display("FAIL conv_count got %0d/%0d want %0d ok=%b", got_a.size(), got_b.size(), exp_a.size(), ok);
    else passed++;
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
      total++;
      if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i])
        $display("FAIL conv_word%0d got %0d/%0d want %0d/%0d", i, got_a[i], got_b[i], exp_a[i], exp_b[i]);
      else passed++;
    end
`ifdef NO_BRDR_CLIP_CNT_EN
    total++;
    if (int'(clip_a) != clip_exp_a || int'(clip_b) != clip_exp_b)
      $display("FAIL conv_clip got %0d/%0d want %0d/%0d", clip_a, clip_b, clip_exp_a, clip_exp_b);
    else passed++;
`endif
  endtask

  task automatic test_overflow();
    bit ok;
    int kc = 0;
    do_reset();
    start_frame(1'b0);
    for (int i = 0; i < W * H; i++) begin
      if (kept_at(i)) kc++;
      sample(rnd_v(), 1'b0);
      if (kept_at(i) && kc == 4) begin
        repeat (3) cyc(1'b0, 1'b0, 0, 1'b0);
        total++;
        if (ovf_a !== 1'b0) $display("FAIL ovf_early got %b want 0", ovf_a); else passed++;
      end
    end
    repeat (3) cyc(1'b0, 1'b0, 0, 1'b0);
    total++;
    if (ovf_a !== 1'b1 || ovf_b !== 1'b0) $display("FAIL ovf_sticky got %b/%b want 1/0", ovf_a, ovf_b); else passed++;
    total++;
    if (val_a !== 1'b1 || int'(pix_a) !== exp_a[0]) $display("FAIL ovf_hold got %b/%0d want 1/%0d", val_a, pix_a, exp_a[0]);
    else passed++;
    while (exp_a.size() > 4) void'(exp_a.pop_back());
    wait_done(200, ok);
    total++;
    if (!ok || got_a.size() != 4 || got_b.size() != exp_b.size())
      $display("FAIL ovf_count got %0d/%0d want 4/%0d ok=%b", got_a.size(), got_b.size(), exp_b.size(), ok);
    else passed++;
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) begin
      total++;
      if (got_b[i] !== exp_b[i] || (i < 4 && i < got_a.size() && got_a[i] !== exp_a[i]))
        $display("FAIL ovf_word%0d got %0d want %0d", i, got_b[i], exp_b[i]);
      else passed++;
    end
    start_frame(1'b1);
    cyc(1'b0, 1'b0, 0, 1'b1);
    total++;
    if (ovf_a !== 1'b0 || busy_a !== 1'b1) $display("FAIL ovf_clear got %b/%b want 0/1", ovf_a, busy_a); else passed++;
  endtask

  task automatic test_full_push_pop();
    bit ok;
    do_reset();
    start_frame(1'b0);
    for (int i = 0; i < W * H; i++) sample(rnd_v(), (i >= IDX5 + 1));
    wait_done(200, ok);
    total++;
    if (!ok || ovf_a !== 1'b0 || got_a.size() != exp_a.size())
      $display("FAIL fpp_status ok=%b ovf=%b got %0d want %0d", ok, ovf_a, got_a.size(), exp_a.size());
    else passed++;
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
      total++;
      if (got_a[i] !== exp_a[i]) $display("FAIL fpp_word%0d got %0d want %0d", i, got_a[i], exp_a[i]); else passed++;
    end
  endtask

  task automatic test_control_edges();
    bit ok;
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, rnd_v(), 1'b1);
    total++;
    if (got_a.size() != 0 || busy_a !== 1'b0) $display("FAIL idle_ignore got %0d words busy=%b want 0/0", got_a.size(), busy_a);
    else passed++;
    start_frame(1'b1);
    for (int i = 0; i < 60; i++) sample(rnd_v(), 1'b1);
    start_frame(1'b1);
    for (int i = 0; i < W * H; i++) sample(rnd_v(), 1'b1);
    wait_done(200, ok);
    total++;
    if (!ok || ndone_a != 1 || got_a.size() != exp_a.size() || got_a.size() == 0)
      $display("FAIL restart_count got %0d want %0d done=%0d", got_a.size(), exp_a.size(), ndone_a);
    else passed++;
    total++;
    if (got_b.size() == 0 || exp_b.size() == 0 || got_b[0] !== exp_b[0])
      $display("FAIL restart_first got %0d words want first %0d", got_b.size(), (exp_b.size() > 0) ? exp_b[0] : -1);
    else passed++;
    start_frame(1'b0);
    for (int i = 0; i < W * H; i++) sample(rnd_v(), 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 0, 1'b0);
    total++;
    if (busy_a !== 1'b1 || ndone_a != 0) $display("FAIL drain_state busy=%b done=%0d want 1/0", busy_a, ndone_a); else passed++;
    @(negedge clk);
    reset_in = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({pix_a, val_a, done_a, ovf_a, busy_a, pix_b, val_b, done_b, ovf_b, busy_b} !== '0)
      $display("FAIL drain_reset got %b/%b/%b/%b/%b want 0", val_a, ovf_a, busy_a, val_b, busy_b);
    else passed++;
    reset_in = 1'b0;
    clear_model();
    repeat (20) cyc(1'b0, 1'b0, 0, 1'b1);
    total++;
    if (ndone_a + ndone_b != 0 || got_a.size() + got_b.size() != 0)
      $display("FAIL drain_abort done=%0d words=%0d want 0/0", ndone_a + ndone_b, got_a.size() + got_b.size());
    else passed++;
  endtask

  task automatic test_random_frames();
    bit ok;
    int cycles;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      start_frame(1'($urandom_range(1)));
      cycles = 0;
      while (n < W * H && cycles < 3000) begin
        if ((exp_a.size() - got_a.size()) < 3 && $urandom_range(9) < 7)
          sample(rnd_v(), 1'($urandom_range(1)));
        else
          cyc(1'b0, 1'b0, 0, 1'($urandom_range(1)));
        cycles++;
      end
      wait_done(300, ok);
      total++;
      if (!ok || n != W * H || ovf_a !== 1'b0 || ovf_b !== 1'b0)
        $display("FAIL rand%0d_status ok=%b n=%0d ovf=%b/%b want 1/%0d/0/0", f, ok, n, ovf_a, ovf_b, W * H);
      else passed++;
      total++;
      if (got_a.size() != exp_a.size() || got_b.size() != exp_b.size())
        $display("FAIL rand%0d_count got %0d/%0d want %0d", f, got_a.size(), got_b.size(), exp_a.size());
      else passed++;
      for (int i = 0; i < got_a.size() && i < exp_a.size() && i < got_b.size(); i++) begin
        total++;
        if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i])
          $display("FAIL rand%0d_word%0d got %0d/%0d want %0d/%0d", f, i, got_a[i], got_b[i], exp_a[i], exp_b[i]);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_crop();
    test_conversion();
    test_overflow();
    test_full_push_pop();
    test_control_edges();
    test_random_frames();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
